// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and DataMemory.
// Stores are accepted in one cycle and drained in order whenever the memory
// port is not claimed by a load. Loads that overlap a pending store raise
// ld_hazard so MEM can stall until the conflicting store has retired.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    // Store request from MEM
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data1,
    input  logic [31:0]      st_data2,
    input  logic             st_byte,
    input  logic             st_double,
    // Load overlap query from MEM
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    input  logic             ld_byte,
    input  logic             ld_double,
    output logic             ld_hazard,
    // DataMemory write port
    input  logic             mem_busy,
    output logic             mem_write,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_in1,
    output logic [31:0]      mem_in2,
    output logic             mem_byte,
    output logic             mem_dWrite,
    // Status
    output logic             empty,
    output logic [PTR_W:0]   count
);

    // Entry storage
    logic [31:0]      r_addr   [DEPTH];
    logic [31:0]      r_data1  [DEPTH];
    logic [31:0]      r_data2  [DEPTH];
    logic             r_byte   [DEPTH];
    logic             r_double [DEPTH];

    // Queue bookkeeping
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Load overlap terms
    logic [3:0]       w_ld_len;
    logic [32:0]      w_ld_lo;
    logic [32:0]      w_ld_hi;
    logic [DEPTH-1:0] w_overlap;

    assign w_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty  = (r_count == '0);

    // Acceptance depends on full alone, so a pop in the same cycle cannot
    // open a slot for a store that is being presented while full.
    assign st_ready = ~w_full;
    assign w_push   = st_valid & ~w_full;
    assign w_pop    = mem_write;

    assign empty    = w_empty;
    assign count    = r_count;

    // Head entry is always presented; only mem_write qualifies it.
    assign mem_write   = ~w_empty & ~mem_busy;
    assign mem_address = r_addr[r_rd_ptr];
    assign mem_in1     = r_data1[r_rd_ptr];
    assign mem_in2     = r_data2[r_rd_ptr];
    assign mem_dWrite  = r_double[r_rd_ptr];
    assign mem_byte    = r_byte[r_rd_ptr] & ~r_double[r_rd_ptr];

    // Capture a store into the tail slot when it is accepted
    // NOTE: the entry arrays carry no reset; validity comes solely from
    // rd_ptr/count, so stale contents are never observed as pending stores.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr]   <= st_addr;
            r_data1[r_wr_ptr]  <= st_data1;
            r_data2[r_wr_ptr]  <= st_data2;
            r_byte[r_wr_ptr]   <= st_byte;
            r_double[r_wr_ptr] <= st_double;
        end
    end

    // Advance pointers and occupancy on push and/or retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Byte range of the load, widened to 33 bits so the end never wraps to 0.
    assign w_ld_len = ld_double ? 4'd8 : (ld_byte ? 4'd1 : 4'd4);
    assign w_ld_lo  = {1'b0, ld_addr};
    assign w_ld_hi  = w_ld_lo + 33'(w_ld_len);

    // Per-slot overlap test; a slot is live if it lies within count of rd_ptr.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [PTR_W-1:0] w_off;
        logic             w_live;
        logic [3:0]       w_len;
        logic [32:0]      w_lo;
        logic [32:0]      w_hi;

        assign w_off        = PTR_W'(g) - r_rd_ptr;
        assign w_live       = ({1'b0, w_off} < r_count);
        assign w_len        = r_double[g] ? 4'd8 : (r_byte[g] ? 4'd1 : 4'd4);
        assign w_lo         = {1'b0, r_addr[g]};
        assign w_hi         = w_lo + 33'(w_len);
        assign w_overlap[g] = w_live & (w_lo < w_ld_hi) & (w_ld_lo < w_hi);
    end

    assign ld_hazard = ld_valid & (|w_overlap);

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed scenarios plus a randomized phase.
// A reference queue of pending stores is updated at each clock edge from the
// drive-side inputs; a monitor on the falling edge compares every DUT output
// against that queue (head contents, drain enable, occupancy, load hazard).
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             st_valid = 1'b0;
    logic             st_ready;
    logic [31:0]      st_addr = '0;
    logic [31:0]      st_data1 = '0;
    logic [31:0]      st_data2 = '0;
    logic             st_byte = 1'b0;
    logic             st_double = 1'b0;
    logic             ld_valid = 1'b0;
    logic [31:0]      ld_addr = '0;
    logic             ld_byte = 1'b0;
    logic             ld_double = 1'b0;
    logic             ld_hazard;
    logic             mem_busy = 1'b0;
    logic             mem_write;
    logic [31:0]      mem_address;
    logic [31:0]      mem_in1;
    logic [31:0]      mem_in2;
    logic             mem_byte;
    logic             mem_dWrite;
    logic             empty;
    logic [PTR_W:0]   count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] d1;
        logic [31:0] d2;
        bit          b;
        bit          d;
    } st_t;

    st_t q[$];

    store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data1    (st_data1),
        .st_data2    (st_data2),
        .st_byte     (st_byte),
        .st_double   (st_double),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_byte     (ld_byte),
        .ld_double   (ld_double),
        .ld_hazard   (ld_hazard),
        .mem_busy    (mem_busy),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_in1     (mem_in1),
        .mem_in2     (mem_in2),
        .mem_byte    (mem_byte),
        .mem_dWrite  (mem_dWrite),
        .empty       (empty),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Access length in bytes from the size flags.
    function automatic longint unsigned acc_len(input bit b, input bit d);
        return d ? 64'd8 : (b ? 64'd1 : 64'd4);
    endfunction

    // Any pending store whose byte range intersects the load range.
    function automatic bit model_hazard(input logic [31:0] la, input bit lb, input bit ld);
        longint unsigned l_lo = {32'b0, la};
        longint unsigned l_hi = l_lo + acc_len(lb, ld);
        foreach (q[i]) begin
            longint unsigned s_lo = {32'b0, q[i].addr};
            longint unsigned s_hi = s_lo + acc_len(q[i].b, q[i].d);
            if (s_lo < l_hi && l_lo < s_hi) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference queue: retire the head if the port is free, accept a store if not full.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (st_valid && q.size() < DEPTH) begin
            if (q.size() != 0 && !mem_busy) void'(q.pop_front());
            q.push_back('{addr: st_addr, d1: st_data1, d2: st_data2, b: st_byte, d: st_double});
        end else if (q.size() != 0 && !mem_busy) begin
            void'(q.pop_front());
        end
    end

    // Monitor: compare all outputs against the reference queue mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("mem_write", mem_write, (q.size() != 0 && !mem_busy));
            if (mem_write && q.size() != 0) begin
                check("mem_address", mem_address, q[0].addr);
                check("mem_in1", mem_in1, q[0].d1);
                check("mem_in2", mem_in2, q[0].d2);
                check("mem_byte", mem_byte, q[0].b & ~q[0].d);
                check("mem_dWrite", mem_dWrite, q[0].d);
            end
            check("count", count, q.size());
            check("empty", empty, q.size() == 0);
            check("st_ready", st_ready, q.size() < DEPTH);
            check("ld_hazard", ld_hazard, ld_valid && model_hazard(ld_addr, ld_byte, ld_double));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d1, input logic [31:0] d2,
                               input bit b, input bit d);
        st_valid  = 1'b1;
        st_addr   = a;
        st_data1  = d1;
        st_data2  = d2;
        st_byte   = b;
        st_double = d;
    endtask

    task automatic drive_load(input logic [31:0] a, input bit b, input bit d);
        ld_valid  = 1'b1;
        ld_addr   = a;
        ld_byte   = b;
        ld_double = d;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (!empty && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", empty, 1'b1);
    endtask

    task automatic fill(input logic [31:0] base);
        for (int k = 0; k < DEPTH; k++) begin
            drive_store(base + 32'(4 * k), $urandom, $urandom, 1'b0, 1'b0);
            step();
        end
        st_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_empty", empty, 1'b1);
        check("rst_st_ready", st_ready, 1'b1);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_ld_hazard", ld_hazard, 1'b0);
        check("rst_count", count, 0);

        // Single word store drains the cycle after it is pushed
        drive_store(32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        step();
        st_valid = 1'b0;
        check("t1_mem_write", mem_write, 1'b1);
        check("t1_addr", mem_address, 32'h10);
        check("t1_in1", mem_in1, 32'hDEADBEEF);
        check("t1_byte", mem_byte, 1'b0);
        check("t1_dwrite", mem_dWrite, 1'b0);
        step();
        check("t1_empty", empty, 1'b1);

        // Fill while the port is busy; a fifth store is refused
        mem_busy = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) begin
            drive_store(32'h100 + 32'(4 * k), $urandom, $urandom, 1'b0, 1'b0);
            step();
        end
        st_valid = 1'b0;
        check("t2_count_full", count, DEPTH);
        check("t2_st_ready", st_ready, 1'b0);
        mem_busy = 1'b0;
        step();
        check("t2_drain_count", count, DEPTH - 1);
        wait_empty(20);
        check("t2_count_zero", count, 0);

        // Overlap rules against double and byte stores
        mem_busy = 1'b1;
        drive_store(32'h20, 32'h11111111, 32'h22222222, 1'b0, 1'b1);
        step();
        st_valid = 1'b0;
        drive_load(32'h24, 1'b0, 1'b0);
        #1 check("t3_dbl_word_in", ld_hazard, 1'b1);
        drive_load(32'h28, 1'b0, 1'b0);
        #1 check("t3_dbl_word_out", ld_hazard, 1'b0);
        ld_valid = 1'b0;
        step();
        drive_store(32'h33, 32'h000000A5, 32'h0, 1'b1, 1'b0);
        step();
        st_valid = 1'b0;
        drive_load(32'h30, 1'b0, 1'b0);
        #1 check("t3_byte_word_in", ld_hazard, 1'b1);
        drive_load(32'h34, 1'b1, 1'b0);
        #1 check("t3_byte_byte_out", ld_hazard, 1'b0);
        ld_valid = 1'b0;
        step();
        mem_busy = 1'b0;
        wait_empty(20);

        // Full with pop refuses the push; then steady push+pop with wrap
        mem_busy = 1'b1;
        fill(32'h200);
        mem_busy = 1'b0;
        drive_store(32'h300, $urandom, $urandom, 1'b0, 1'b0);
        #1 check("t4_full_ready", st_ready, 1'b0);
        step();
        check("t4_count_after_pop", count, DEPTH - 1);
        for (int k = 0; k < 2 * DEPTH; k++) begin
            drive_store(32'h400 + 32'(4 * k), $urandom, $urandom, 1'(k & 1), 1'((k >> 1) & 1));
            step();
            check("t4_count_steady", count, DEPTH - 1);
        end
        st_valid = 1'b0;
        wait_empty(20);

        // No 32-bit wrap in the overlap computation
        mem_busy = 1'b1;
        drive_store(32'hFFFFFFFC, 32'hCAFEF00D, 32'h12345678, 1'b0, 1'b1);
        step();
        st_valid = 1'b0;
        drive_load(32'h0, 1'b1, 1'b0);
        #1 check("t5_no_wrap", ld_hazard, 1'b0);
        drive_load(32'hFFFFFFFF, 1'b1, 1'b0);
        #1 check("t5_top_byte", ld_hazard, 1'b1);
        ld_valid = 1'b0;
        #1 check("t5_ld_invalid", ld_hazard, 1'b0);
        step();
        mem_busy = 1'b0;
        wait_empty(20);

        // Asynchronous reset in the middle of a drain
        mem_busy = 1'b1;
        fill(32'h500);
        mem_busy = 1'b0;
        step();
        check("t6_count_pre", count, DEPTH - 1);
        check("t6_write_pre", mem_write, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_write", mem_write, 1'b0);
        check("t6_rst_empty", empty, 1'b1);
        check("t6_rst_count", count, 0);
        check("t6_rst_ready", st_ready, 1'b1);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t6_no_write", mem_write, 1'b0);
        end

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            st_valid = 1'b0;
            ld_valid = 1'b0;
            mem_busy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                drive_store(32'h40 + 32'($urandom_range(0, 31)), $urandom, $urandom,
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
            end else if ($urandom_range(0, 1) == 1) begin
                drive_load(32'h40 + 32'($urandom_range(0, 31)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
            end
            step();
        end
        st_valid = 1'b0;
        ld_valid = 1'b0;
        mem_busy = 1'b0;
        wait_empty(20);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
